// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, major-opcode constants and
// the write-back stage state encoding.
package pipeline_pkg;

    localparam int XLEN = 32;

    // Major opcode field, instruction bits [6:2]
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_MAC    = 5'b11111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    function automatic logic is_mac_opcode(input logic [4:0] opc);
        return opc == OP_MAC;
    endfunction

    function automatic logic opcode_writes_rd(input logic [4:0] opc);
        return (opc == OP_R) || (opc == OP_I) || (opc == OP_LOAD) || (opc == OP_MAC);
    endfunction

endpackage

// File: rtl/mac_seq_mult.sv
// Sequential shift-add multiply-accumulate: one multiplier bit per cycle,
// XLEN steps after start; result is valid in the cycle done is high.
module mac_seq_mult #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] acc,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] prod_q;
    logic [XLEN-1:0] acc_q;
    logic [CW-1:0]   cnt_q;
    logic            running_q;
    logic [XLEN-1:0] prod_d;

    // done fires on the final step so the parent can register the sum directly
    always_comb begin
        prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        done   = running_q && (cnt_q == LAST_STEP);
        result = prod_d + acc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            mcand_q   <= a;
            mplier_q  <= b;
            prod_q    <= '0;
            acc_q     <= acc;
            cnt_q     <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            prod_q    <= prod_d;
            mcand_q   <= mcand_q << 1;
            mplier_q  <= mplier_q >> 1;
            cnt_q     <= cnt_q + 1'b1;
            running_q <= !done;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, write-back mux and the multi-cycle
// MAC sequencer driving the register-file write port.
module writeback_stage #(
    parameter int XLEN        = 32,
    parameter bit SUPPRESS_X0 = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            memtoreg,
    input  logic            regwrite_in,
    input  logic            mac_in,
    input  logic [4:0]      write_reg_in,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] mac_a,
    input  logic [XLEN-1:0] mac_b,
    input  logic [XLEN-1:0] mac_acc,
    output logic            regwrite,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] writetoreg,
    output logic            stall_signal,
    output logic            busy
);

    import pipeline_pkg::*;

    wb_state_t       state_q, state_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      write_reg_q, write_reg_d;
    logic [XLEN-1:0] writetoreg_q, writetoreg_d;
    logic [4:0]      mac_rd_q, mac_rd_d;

    logic            accept;
    logic            mac_start;
    logic            mult_done;
    logic [XLEN-1:0] mult_result;

    function automatic logic rf_write_ok(input logic [4:0] idx);
        return !(SUPPRESS_X0 && (idx == 5'd0));
    endfunction

    assign accept    = in_valid && (state_q != MUL);
    assign mac_start = accept && mac_in;

    mac_seq_mult #(
        .XLEN(XLEN)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (mac_start),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (mac_acc),
        .done  (mult_done),
        .result(mult_result)
    );

    always_comb begin
        state_d      = state_q;
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        writetoreg_d = writetoreg_q;
        mac_rd_d     = mac_rd_q;
        case (state_q)
            MUL: begin
                if (mult_done) begin
                    state_d      = DONE;
                    regwrite_d   = rf_write_ok(mac_rd_q);
                    write_reg_d  = mac_rd_q;
                    writetoreg_d = mult_result;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives
                state_d = IDLE;
                if (accept) begin
                    if (mac_in) begin
                        state_d  = MUL;
                        mac_rd_d = write_reg_in;
                    end else begin
                        regwrite_d   = regwrite_in && rf_write_ok(write_reg_in);
                        write_reg_d  = write_reg_in;
                        writetoreg_d = memtoreg ? mem_data : alu_result;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            writetoreg_q <= '0;
            mac_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            writetoreg_q <= writetoreg_d;
            mac_rd_q     <= mac_rd_d;
        end
    end

    assign regwrite     = regwrite_q;
    assign write_reg    = write_reg_q;
    assign writetoreg   = writetoreg_q;
    assign stall_signal = (state_q == MUL);
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; the producer end of the decode stage's register-file write port.
- Holds the MEM/WB register and selects the ALU result or the load data for write-back.
- Executes the custom MAC instruction (opcode[6:2]=5'b11111) as a multi-cycle shift-add multiply-accumulate.
- Drives regwrite/write_reg/writetoreg into the register file and asserts stall_signal upstream while a MAC is in flight.

Parameters:
- XLEN, 32, datapath width; MAC iteration count equals XLEN.
- SUPPRESS_X0, 1, when 1 any write targeting register 0 is dropped (regwrite forced low).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  MEM stage presents a retiring instruction this cycle
- memtoreg  in  1  1: write mem_data, 0: write alu_result
- regwrite_in  in  1  instruction writes a register
- mac_in  in  1  instruction is MAC
- write_reg_in  in  5  destination register index
- alu_result  in  XLEN  ALU output
- mem_data  in  XLEN  load data
- mac_a  in  XLEN  MAC multiplicand (rs1 value)
- mac_b  in  XLEN  MAC multiplier (rs2 value)
- mac_acc  in  XLEN  MAC accumulator (rd value, decode dest_reg)
- regwrite  out  1  register-file write enable
- write_reg  out  5  register-file write index
- writetoreg  out  XLEN  register-file write data
- stall_signal  out  1  upstream must hold its outputs
- busy  out  1  MAC in progress (state != IDLE)

Behaviour:
- Reset, asynchronous: state=IDLE, regwrite=0, write_reg=0, writetoreg=0, stall_signal=0, busy=0, iteration counter=0, product/operand registers=0. An in-flight MAC is aborted and no write occurs.
- States are IDLE, MUL, DONE.
- Accepting an instruction: it is accepted at a rising edge when in_valid=1 and the state is IDLE or DONE. Inputs while stall_signal=1 are ignored; upstream holds them.
- Non-MAC accept (mac_in=0) at edge N:
  - During cycle N+1: regwrite = regwrite_in & !(SUPPRESS_X0 & write_reg_in==0).
  - write_reg = write_reg_in.
  - writetoreg = memtoreg ? mem_data : alu_result.
  - Latency is 1 cycle; back-to-back accepts give one write per cycle.
- regwrite is a single-cycle pulse per instruction. With no accept at an edge, regwrite is 0 in the following cycle; write_reg and writetoreg hold their last values.
- MAC accept (mac_in=1) at edge N:
  - Latch mac_a, mac_b, mac_acc and write_reg_in; clear the product and counter; go to MUL.
  - regwrite=0 during cycle N+1.
- MUL, one step per cycle: if multiplier bit0 is set, product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++.
  - Arithmetic is modulo 2^XLEN; only the low XLEN bits are kept, so the result is identical for signed and unsigned operands.
  - After XLEN iterations (cycles N+1..N+XLEN) go to DONE.
  - stall_signal=1 and busy=1 throughout MUL.
- DONE, cycle N+XLEN+1:
  - regwrite=1 (subject to x0 suppression), write_reg=latched rd, writetoreg=(product+acc) mod 2^XLEN.
  - stall_signal=0 and busy=1; a new instruction may be accepted at the edge ending DONE.
  - Next state is MUL if a MAC is accepted, else IDLE.
- regwrite_in is ignored for MAC; MAC always writes.
- An accept whose regwrite_in=0 (e.g. store or branch) still advances the pipeline but produces regwrite=0.

Decomposition:
- Shared package `pipeline_pkg`:
  - XLEN.
  - opcode constants: R=5'b01100, I=5'b00100, LOAD=5'b00000, STORE=5'b01000, BRANCH=5'b11000, MAC=5'b11111.
  - Write-back state enum {IDLE, MUL, DONE}.
- One sub-module, `mac_seq_mult`:
  - Inputs: start, a, b, acc.
  - Outputs: done, result.
  - Contains the operand/product registers and the counter.
- The parent owns the FSM, the MEM/WB register and the write mux.

Test Plan:
- ALU write: in_valid=1, memtoreg=0, regwrite_in=1, write_reg_in=5, alu_result=0x0000002A -> next cycle regwrite=1, write_reg=5, writetoreg=0x2A; the cycle after, regwrite=0.
- Load write back-to-back: load with memtoreg=1, mem_data=0xDEADBEEF to x3, then ALU 0x11 to x4 on consecutive cycles -> two consecutive regwrite pulses with writetoreg=0xDEADBEEF then 0x11.
- MAC basic: mac_a=3, mac_b=4, mac_acc=5, rd=7 accepted at edge N, plus a following instruction presented at N+1:
  - stall_signal=1 for cycles N+1..N+32;
  - regwrite=1, writetoreg=17, write_reg=7 at cycle N+33;
  - the held instruction is accepted at the edge ending N+33.
- MAC wrap-around: mac_a=mac_b=0xFFFFFFFF, mac_acc=0xFFFFFFFF -> writetoreg=0x00000000 (product low word 1, plus acc wraps).
- x0 suppression: ALU write and MAC with write_reg_in=0 -> regwrite stays 0 throughout.
- Reset mid-MAC: assert reset at cycle N+10 of a MAC -> all outputs 0 immediately; after release state=IDLE, no regwrite pulse, a new ALU instruction writes normally one cycle after accept.
